// File: rtl/kyber_pkg.sv
// Shared Kyber constants, coefficient type and the encapsulation-add FSM state encoding.
package kyber_pkg;

   localparam int KYBER_N = 256;
   localparam int KYBER_Q = 3329;
   localparam int CW      = 12;

   typedef logic [CW-1:0] coeff_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ADD_U = 2'd1,
      ST_ADD_V = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/add3_modq.sv
// One coefficient lane: a + b + c followed by a conditional subtract of 2Q or Q.
// With c tied to zero this is the ordinary two-operand modular add.
module add3_modq
   import kyber_pkg::*;
#(
   parameter int Q = KYBER_Q
) (
   input  coeff_t a,
   input  coeff_t b,
   input  coeff_t c,
   output coeff_t s
);

   localparam logic [13:0] Q1 = 14'(Q);
   localparam logic [13:0] Q2 = 14'(2 * Q);

   logic [13:0] sum;

   always_comb begin
      sum = 14'(a) + 14'(b) + 14'(c);
      if (sum >= Q2) begin
         s = coeff_t'(sum - Q2);
      end else if (sum >= Q1) begin
         s = coeff_t'(sum - Q1);
      end else begin
         s = coeff_t'(sum);
      end
   end

endmodule

// File: rtl/enc_add_modq.sv
// Kyber encapsulation add: u[k] = x[k] + e_1[k], v = y + e_2 + msg_poly (mod Q),
// LANES coefficients per cycle through one shared bank of adder lanes.
module enc_add_modq
   import kyber_pkg::*;
#(
   parameter int KYBER_K = 3,
   parameter int LANES   = 16,
   parameter int Q       = KYBER_Q
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   start,
   input  logic [KYBER_K-1:0][KYBER_N*CW-1:0]     x,
   input  logic [KYBER_K-1:0][KYBER_N*CW-1:0]     e_1,
   input  logic [KYBER_N*CW-1:0]                  y,
   input  logic [KYBER_N*CW-1:0]                  e_2,
   input  logic [KYBER_N*CW-1:0]                  msg_poly,
   output logic [KYBER_K-1:0][KYBER_N*CW-1:0]     u,
   output logic [KYBER_N*CW-1:0]                  v,
   output logic                                   busy,
   output logic                                   done,
   output state_t                                 state_dbg
);

   localparam int C     = KYBER_N / LANES;
   localparam int CB    = (C > 1) ? $clog2(C) : 1;
   localparam int KB    = $clog2(KYBER_K);
   localparam int CHUNK = LANES * CW;

   localparam logic [CB-1:0] C_LAST = CB'(C - 1);
   localparam logic [KB-1:0] K_LAST = KB'(KYBER_K - 1);

   state_t          state;
   logic [KB-1:0]   k;
   logic [CB-1:0]   c;

   logic [CHUNK-1:0] op_a;
   logic [CHUNK-1:0] op_b;
   logic [CHUNK-1:0] op_c;
   logic [CHUNK-1:0] sum_chunk;

   assign state_dbg = state;

   // Only the current chunk is routed to the lanes; the third operand is zero during ADD_U.
   always_comb begin
      op_a = '0;
      op_b = '0;
      op_c = '0;
      case (state)
         ST_ADD_U: begin
            op_a = x[k][int'(c) * CHUNK +: CHUNK];
            op_b = e_1[k][int'(c) * CHUNK +: CHUNK];
         end
         ST_ADD_V: begin
            op_a = y[int'(c) * CHUNK +: CHUNK];
            op_b = e_2[int'(c) * CHUNK +: CHUNK];
            op_c = msg_poly[int'(c) * CHUNK +: CHUNK];
         end
         default: ;
      endcase
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      add3_modq #(.Q(Q)) u_lane (
         .a (op_a[i*CW +: CW]),
         .b (op_b[i*CW +: CW]),
         .c (op_c[i*CW +: CW]),
         .s (sum_chunk[i*CW +: CW])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         k     <= '0;
         c     <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         u     <= '0;
         v     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_ADD_U;
                  k     <= '0;
                  c     <= '0;
                  busy  <= 1'b1;
               end
            end
            ST_ADD_U: begin
               u[k][int'(c) * CHUNK +: CHUNK] <= sum_chunk;
               if (c == C_LAST) begin
                  c <= '0;
                  if (k == K_LAST) begin
                     k     <= '0;
                     state <= ST_ADD_V;
                  end else begin
                     k <= k + 1'b1;
                  end
               end else begin
                  c <= c + 1'b1;
               end
            end
            ST_ADD_V: begin
               v[int'(c) * CHUNK +: CHUNK] <= sum_chunk;
               if (c == C_LAST) begin
                  c     <= '0;
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  c <= c + 1'b1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_enc_add_modq.sv
// Directed bench for enc_add_modq: default build (K=3, LANES=16) plus a K=4, LANES=256 build.
module tb_enc_add_modq;
   import kyber_pkg::*;

   localparam int P    = KYBER_N * CW;
   localparam int LAT  = 3 * 16 + 16 + 1;
   localparam int LAT2 = 4 * 1 + 1 + 1;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic start2;

   logic [2:0][P-1:0] x, e_1, u;
   logic [P-1:0]      y, e_2, msg_poly, v;
   logic              busy, done;
   state_t            sdbg;

   logic [3:0][P-1:0] x2, e_12, u2;
   logic [P-1:0]      y2, e_22, m2, v2;
   logic              busy2, done2;
   state_t            sdbg2;

   int checks = 0;
   int errors = 0;
   logic [CW-1:0] exp_q[$];

   always #5 clk = ~clk;

   enc_add_modq dut (
      .clk(clk), .rst(rst), .start(start),
      .x(x), .e_1(e_1), .y(y), .e_2(e_2), .msg_poly(msg_poly),
      .u(u), .v(v), .busy(busy), .done(done), .state_dbg(sdbg)
   );

   enc_add_modq #(.KYBER_K(4), .LANES(256)) dut2 (
      .clk(clk), .rst(rst), .start(start2),
      .x(x2), .e_1(e_12), .y(y2), .e_2(e_22), .msg_poly(m2),
      .u(u2), .v(v2), .busy(busy2), .done(done2), .state_dbg(sdbg2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   task automatic push_u(input logic [P-1:0] a, input logic [P-1:0] b);
      for (int i = 0; i < KYBER_N; i++)
         exp_q.push_back(CW'((int'(a[i*CW +: CW]) + int'(b[i*CW +: CW])) % KYBER_Q));
   endtask

   task automatic push_v(input logic [P-1:0] a, input logic [P-1:0] b, input logic [P-1:0] m);
      for (int i = 0; i < KYBER_N; i++)
         exp_q.push_back(CW'((int'(a[i*CW +: CW]) + int'(b[i*CW +: CW]) + int'(m[i*CW +: CW])) % KYBER_Q));
   endtask

   // Pops one polynomial of expectations and reports the first differing coefficient.
   task automatic check_poly(input string tag, input logic [P-1:0] got);
      logic [CW-1:0] e, g, ge, ee;
      int idx;
      bit found;
      found = 0;
      idx = 0;
      ge = '0;
      ee = '1;
      for (int i = 0; i < KYBER_N; i++) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
         g = got[i*CW +: CW];
         if (i == 0) begin ge = g; ee = e; end
         if (!found && g !== e) begin
            found = 1; idx = i; ge = g; ee = e;
         end
      end
      checks++;
      assert (ge === ee) else begin
         errors++;
         $error("FAIL %s coeff %0d got %0d exp %0d", tag, idx, ge, ee);
      end
   endtask

   task automatic check_dut1(input string tag);
      for (int k = 0; k < 3; k++) begin
         push_u(x[k], e_1[k]);
         check_poly($sformatf("%s_u%0d", tag, k), u[k]);
      end
      push_v(y, e_2, msg_poly);
      check_poly($sformatf("%s_v", tag), v);
   endtask

   // Value < 0 means random canonical coefficients.
   function automatic logic [CW-1:0] pick(input int val);
      return (val < 0) ? CW'($urandom_range(0, KYBER_Q - 1)) : CW'(val);
   endfunction

   task automatic fill1(input int xv, input int ev, input int yv, input int e2v, input int mv);
      for (int i = 0; i < KYBER_N; i++) begin
         for (int k = 0; k < 3; k++) begin
            x[k][i*CW +: CW]   = pick(xv);
            e_1[k][i*CW +: CW] = pick(ev);
         end
         y[i*CW +: CW]        = pick(yv);
         e_2[i*CW +: CW]      = pick(e2v);
         msg_poly[i*CW +: CW] = pick(mv);
      end
   endtask

   // Called at a falling edge. Cycle n counts from the edge that samples start.
   task automatic run_op(input int extra_start, input int rst_at);
      int dones;
      dones = 0;
      start = 1'b1;
      @(posedge clk);
      for (int n = 1; n <= LAT + 3; n++) begin
         @(negedge clk);
         start = 1'b0;
         if (n == extra_start || n == LAT) start = 1'b1;
         if (rst_at > 0 && n == rst_at) rst = 1'b1;
         if (rst_at > 0 && n == rst_at + 1) begin
            rst = 1'b0;
            chk("abort_busy", 32'(busy), 0);
            chk("abort_done", 32'(done), 0);
            chk("abort_u_zero", 32'(u === '0), 1);
            chk("abort_v_zero", 32'(v === '0), 1);
            chk("abort_state", 32'(sdbg), 32'(ST_IDLE));
            return;
         end
         if (done) dones++;
         chk($sformatf("busy_c%0d", n), 32'(busy), (n < LAT) ? 1 : 0);
         chk($sformatf("done_c%0d", n), 32'(done), (n == LAT) ? 1 : 0);
      end
      start = 1'b0;
      chk("done_pulses", dones, 1);
   endtask

   task automatic run_op2();
      start2 = 1'b1;
      @(posedge clk);
      for (int n = 1; n <= LAT2 + 2; n++) begin
         @(negedge clk);
         start2 = 1'b0;
         chk($sformatf("busy2_c%0d", n), 32'(busy2), (n < LAT2) ? 1 : 0);
         chk($sformatf("done2_c%0d", n), 32'(done2), (n == LAT2) ? 1 : 0);
      end
   endtask

   task automatic rand_op2(input string tag);
      for (int i = 0; i < KYBER_N; i++) begin
         for (int k = 0; k < 4; k++) begin
            x2[k][i*CW +: CW]   = pick(-1);
            e_12[k][i*CW +: CW] = pick(-1);
         end
         y2[i*CW +: CW]  = pick(-1);
         e_22[i*CW +: CW] = pick(-1);
         m2[i*CW +: CW]  = pick(-1);
      end
      run_op2();
      for (int k = 0; k < 4; k++) begin
         push_u(x2[k], e_12[k]);
         check_poly($sformatf("%s_u%0d", tag, k), u2[k]);
      end
      push_v(y2, e_22, m2);
      check_poly($sformatf("%s_v", tag), v2);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      start2 = 1'b0;
      fill1(0, 0, 0, 0, 0);
      x2 = '0; e_12 = '0; y2 = '0; e_22 = '0; m2 = '0;
      repeat (3) @(negedge clk);

      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_state", 32'(sdbg), 32'(ST_IDLE));
      chk("rst_u_zero", 32'(u === '0), 1);
      chk("rst_v_zero", 32'(v === '0), 1);
      chk("rst2_busy", 32'(busy2), 0);
      chk("rst2_state", 32'(sdbg2), 32'(ST_IDLE));
      rst = 1'b0;
      @(negedge clk);

      // All-zero operands.
      run_op(0, 0);
      check_dut1("zero");

      // Wrap to zero in u, double wrap in v; a second start mid-run and one in DONE are ignored.
      fill1(3328, 1, 3328, 3328, 1665);
      run_op(10, 0);
      chk("u_wrap_zero", 32'(u[1][5*CW +: CW]), 0);
      chk("v_double_wrap", 32'(v[100*CW +: CW]), 1663);
      check_dut1("wrap");

      // No wrap in u; only the last v coefficient carries operands.
      fill1(1000, 2000, 0, 0, 0);
      y[255*CW +: CW] = 12'd3328;
      e_2[255*CW +: CW] = 12'd3328;
      msg_poly[255*CW +: CW] = 12'd3328;
      run_op(0, 0);
      chk("u_nowrap", 32'(u[2][200*CW +: CW]), 3000);
      chk("v_last", 32'(v[255*CW +: CW]), 3326);
      chk("v_last_minus1", 32'(v[254*CW +: CW]), 0);
      check_dut1("nowrap");

      // Abort at cycle 30, then restart right after reset drops.
      fill1(-1, -1, -1, -1, -1);
      run_op(0, 30);
      run_op(0, 0);
      check_dut1("after_abort");

      rand_op2("k4l256_a");
      rand_op2("k4l256_b");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
